// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Purpose  : Instruction fetch stage of the mini-rv pipeline. Holds the
//             fetch PC, issues word requests to instruction memory over a
//             valid/ready channel, buffers in-order responses in a small
//             FIFO and presents one registered {instr, pc, instr_valid} per
//             cycle to decode. Honours the decode stall and the execute
//             redirect.
//  Ports    : clk, rst (sync, active-low)
//             imem_req_valid/ready/addr   - request channel to memory
//             imem_rsp_valid/data         - in-order responses from memory
//             redirect_valid/pc           - control-flow change from execute
//             stall                       - decode cannot accept
//             instr/pc/instr_valid        - registered output to decode
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic        instr_valid
);

    localparam int          PTR_W     = $clog2(FIFO_DEPTH);
    localparam int          CNT_W     = PTR_W + 1;
    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [CNT_W:0] DEPTH_EXT = FIFO_DEPTH[CNT_W:0];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]      req_pc_q, req_pc_d;
    logic [31:0]      rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      pc_q, pc_d;
    logic             instr_valid_q, instr_valid_d;

    logic [31:0]      fifo_instr_q [FIFO_DEPTH];
    logic [31:0]      fifo_pc_q    [FIFO_DEPTH];

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic [CNT_W:0]   w_credit_used;
    logic             w_req_valid;
    logic             w_req_fire;
    logic             w_rsp_live;
    logic             w_fifo_empty;
    logic             w_bypass;
    logic             w_push;
    logic             w_pop;
    logic [31:0]      w_redirect_addr;
    logic [CNT_W-1:0] w_fire_ext;
    logic [CNT_W-1:0] w_rsp_ext;
    logic [CNT_W-1:0] w_push_ext;
    logic [CNT_W-1:0] w_pop_ext;
    logic             w_unused_rpc_lsb;

    // Requests already in flight plus responses parked in the FIFO may never
    // exceed the FIFO depth, so every response always has a slot to land in.
    assign w_credit_used   = {1'b0, inflight_q} + {1'b0, count_q};
    assign w_req_valid     = rst & ~redirect_valid & (w_credit_used < DEPTH_EXT);
    assign w_req_fire      = w_req_valid & imem_req_ready;

    // A response is live only if it belongs to the current fetch stream:
    // stale ones (counted by drop) and any arriving during a redirect vanish.
    assign w_rsp_live      = imem_rsp_valid & ~redirect_valid & (drop_q == '0);
    assign w_fifo_empty    = (count_q == '0);

    // With an empty FIFO a live response goes straight to the output register
    // so the fetch loop costs only one cycle from response to instr_valid.
    assign w_bypass        = w_rsp_live & ~stall & w_fifo_empty;
    assign w_push          = w_rsp_live & ~w_bypass;
    assign w_pop           = ~redirect_valid & ~stall & ~w_fifo_empty;

    assign w_redirect_addr = {redirect_pc[31:2], 2'b00};
    assign w_unused_rpc_lsb = ^redirect_pc[1:0];

    assign w_fire_ext      = {{(CNT_W-1){1'b0}}, w_req_fire};
    assign w_rsp_ext       = {{(CNT_W-1){1'b0}}, imem_rsp_valid};
    assign w_push_ext      = {{(CNT_W-1){1'b0}}, w_push};
    assign w_pop_ext       = {{(CNT_W-1){1'b0}}, w_pop};

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        req_pc_d      = req_pc_q;
        rsp_pc_d      = rsp_pc_q;
        drop_d        = drop_q;
        count_d       = count_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        instr_d       = instr_q;
        pc_d          = pc_q;
        instr_valid_d = instr_valid_q;

        // Every response retires one outstanding request, live or stale.
        inflight_d    = inflight_q + w_fire_ext - w_rsp_ext;

        if (redirect_valid) begin
            req_pc_d      = w_redirect_addr;
            rsp_pc_d      = w_redirect_addr;
            // Everything still outstanding after this cycle is stale.
            drop_d        = inflight_d;
            count_d       = '0;
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            instr_d       = NOP;
            instr_valid_d = 1'b0;
        end else begin
            if (w_req_fire) begin
                req_pc_d = req_pc_q + 32'd4;
            end
            if (imem_rsp_valid && (drop_q != '0)) begin
                drop_d = drop_q - {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (w_rsp_live) begin
                rsp_pc_d = rsp_pc_q + 32'd4;
            end
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            count_d = count_q + w_push_ext - w_pop_ext;

            if (!stall) begin
                if (w_bypass) begin
                    instr_d       = imem_rsp_data;
                    pc_d          = rsp_pc_q;
                    instr_valid_d = 1'b1;
                end else if (w_pop) begin
                    instr_d       = fifo_instr_q[rd_ptr_q];
                    pc_d          = fifo_pc_q[rd_ptr_q];
                    instr_valid_d = 1'b1;
                end else begin
                    // Nothing to hand over: emit a bubble, pc keeps its value.
                    instr_d       = NOP;
                    instr_valid_d = 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            req_pc_q      <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            inflight_q    <= '0;
            drop_q        <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            instr_q       <= NOP;
            pc_q          <= 32'h0000_0000;
            instr_valid_q <= 1'b0;
        end else begin
            req_pc_q      <= req_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            inflight_q    <= inflight_d;
            drop_q        <= drop_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            instr_q       <= instr_d;
            pc_q          <= pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    // Response storage needs no reset: count/pointers qualify its contents.
    always_ff @(posedge clk) begin
        if (rst && w_push) begin
            fifo_instr_q[wr_ptr_q] <= imem_rsp_data;
            fifo_pc_q[wr_ptr_q]    <= rsp_pc_q;
        end
    end

    // ------------------------------------------------------------------
    // Invariants of the credit scheme
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!(w_push && (count_q == DEPTH_EXT[CNT_W-1:0])));
            assert (!(imem_rsp_valid && (inflight_q == '0)));
            assert (drop_q <= inflight_q);
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = req_pc_q;
    assign instr          = instr_q;
    assign pc             = pc_q;
    assign instr_valid    = instr_valid_q;

endmodule
`default_nettype wire
